// File: rtl/ecdh_pkg.sv
// rtl/ecdh_pkg.sv - shared ECDH datapath types and constants
// Contents: default field/digit widths, digit-count helper, multiplier FSM states.
package ecdh_pkg;

  localparam int BW_GF_DEF    = 192;
  localparam int BW_DIGIT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  // Number of multiplier digits consumed per product.
  function automatic int nd(input int bw_gf, input int bw_digit);
    return bw_gf / bw_digit;
  endfunction

endpackage

// File: rtl/mult_digit_serial_if.sv
// rtl/mult_digit_serial_if.sv - operand/result handshake bundle for the digit-serial multiplier
// Signals: in_valid/in_ready/a/b/sq_mode (operand side), out_valid/out_ready/prod (result side), busy.
// master: operand producer and result consumer; slave: the multiplier.
interface mult_digit_serial_if #(
  parameter int BW_GF = ecdh_pkg::BW_GF_DEF
);

  logic               in_valid;
  logic               in_ready;
  logic [BW_GF-1:0]   a;
  logic [BW_GF-1:0]   b;
  logic               sq_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*BW_GF-1:0] prod;
  logic               busy;

  modport master (
    output in_valid, a, b, sq_mode, out_ready,
    input  in_ready, out_valid, prod, busy
  );

  modport slave (
    input  in_valid, a, b, sq_mode, out_ready,
    output in_ready, out_valid, prod, busy
  );

endinterface

// File: rtl/mult_digit_serial_pe.sv
// rtl/mult_digit_serial_pe.sv - combinational digit processing element
// Ports: a_op (multiplicand), digit (current multiplier digit), acc_hi (upper accumulator half),
//        psum = a_op * digit + acc_hi, BW_GF+BW_DIGIT bits wide.
// Isolated from the control path so it can be retimed or pipelined on its own.
module mult_digit_pe #(
  parameter int BW_GF    = ecdh_pkg::BW_GF_DEF,
  parameter int BW_DIGIT = ecdh_pkg::BW_DIGIT_DEF
) (
  input  logic [BW_GF-1:0]          a_op,
  input  logic [BW_DIGIT-1:0]       digit,
  input  logic [BW_GF-1:0]          acc_hi,
  output logic [BW_GF+BW_DIGIT-1:0] psum
);

  localparam int PW = BW_GF + BW_DIGIT;

  // (2^G-1)(2^D-1) + (2^G-1) < 2^(G+D), so PW bits never overflow.
  always_comb begin
    psum = PW'(a_op) * PW'(digit) + PW'(acc_hi);
  end

endmodule

// File: rtl/mult_digit_serial.sv
// rtl/mult_digit_serial.sv - digit-serial BW_GF x BW_GF multiplier with valid/ready handshake
// Ports: clk, rst (async, active-high), bus (slave modport: in_valid/in_ready/a/b/sq_mode,
//        out_valid/out_ready/prod, busy). One BW_DIGIT multiplier digit per cycle, LSB first.
module mult_digit_serial
  import ecdh_pkg::*;
#(
  parameter int BW_GF    = BW_GF_DEF,
  parameter int BW_DIGIT = BW_DIGIT_DEF
) (
  input logic               clk,
  input logic               rst,
  mult_digit_serial_if.slave bus
);

  localparam int ND = nd(BW_GF, BW_DIGIT);
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ND - 1);

  generate
    if ((BW_GF % BW_DIGIT) != 0) begin : g_bad_digit
      $error("mult_digit_serial: BW_DIGIT must divide BW_GF");
    end
  endgenerate

  mult_state_e          state_q, state_d;
  logic [BW_GF-1:0]     a_r, b_r;
  logic [2*BW_GF-1:0]   acc_q;
  logic [2*BW_GF-1:0]   acc_next;
  logic [2*BW_GF-1:0]   prod_q;
  logic [CW-1:0]        cnt_q;
  logic [BW_DIGIT-1:0]  digit;
  logic [BW_GF+BW_DIGIT-1:0] psum;
  logic                 in_ready_c, out_valid_c, busy_c;
  logic                 accept, last;

  assign digit    = b_r[int'(cnt_q)*BW_DIGIT +: BW_DIGIT];
  // Each step retires BW_DIGIT low product bits into the bottom of acc.
  assign acc_next = {psum, acc_q[BW_GF-1:BW_DIGIT]};
  assign last     = (cnt_q == CNT_LAST);
  assign accept   = bus.in_valid && in_ready_c;

  mult_digit_pe #(
    .BW_GF    (BW_GF),
    .BW_DIGIT (BW_DIGIT)
  ) u_pe (
    .a_op   (a_r),
    .digit  (digit),
    .acc_hi (acc_q[2*BW_GF-1 -: BW_GF]),
    .psum   (psum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // in_ready depends combinationally on out_ready so a finished result
  // can be drained and a new operand set taken in the same cycle.
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = CALC;
      end
      CALC: begin
        busy_c = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        in_ready_c  = bus.out_ready;
        if (bus.out_ready) state_d = bus.in_valid ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else if (accept) begin
      a_r   <= bus.a;
      // Squaring never samples b, so an undriven b cannot reach prod.
      b_r   <= bus.sq_mode ? bus.a : bus.b;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == CALC) begin
      acc_q <= acc_next;
      cnt_q <= last ? '0 : cnt_q + 1'b1;
      if (last) prod_q <= acc_next;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.prod      = prod_q;

endmodule

// File: doc/mult_digit_serial.md
# mult_digit_serial

Parametrised digit-serial multiplier for the ECDH datapath. It computes the full 2·BW_GF-bit product of two BW_GF-bit operands, consuming one BW_DIGIT-bit digit of the multiplier per cycle. It adds a valid/ready handshake on both sides, output holding under back-pressure, back-to-back issue and a squaring mode. It sits in front of the modular-reduction stage, which consumes `prod`.

## Interface
Parameters:
- BW_GF, 192, operand width in bits.
- BW_DIGIT, 16, digit width in bits. Must divide BW_GF exactly. Elaboration fails otherwise.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands present on `a`, `b`, `sq_mode`.
- in_ready  out  1  block accepts operands this cycle.
- a  in  BW_GF  multiplicand.
- b  in  BW_GF  multiplier; ignored when `sq_mode`=1.
- sq_mode  in  1  1: compute a·a.
- out_valid  out  1  `prod` holds a finished result.
- out_ready  in  1  downstream accepts `prod`.
- prod  out  2·BW_GF  product, registered.
- busy  out  1  high in CALC.

## Operation
- Derived constant: ND = BW_GF/BW_DIGIT.
- States:
  - IDLE: `in_ready`=1.
  - CALC: digit counter `cnt` runs 0..ND-1.
  - DONE: `out_valid`=1.
- Accept: an operand set is accepted when `in_valid` && `in_ready`. On accept:
  - latch `a` into A_r.
  - latch `sq_mode ? a : b` into B_r.
  - clear acc (2·BW_GF bits).
  - set `cnt` to 0 and go to CALC.
- CALC step, each cycle:
  - psum = A_r·B_r[cnt·BW_DIGIT +: BW_DIGIT] + acc[2·BW_GF-1 -: BW_GF]. psum is BW_GF+BW_DIGIT bits and cannot overflow.
  - acc ← {psum, acc[BW_GF-1 : BW_DIGIT]}, i.e. a right shift of BW_DIGIT bits per step.
  - cnt ← cnt+1.
- End of CALC: when `cnt`=ND-1, the same edge copies the new acc value into `prod` and moves to DONE.
- DONE:
  - `prod` and `out_valid` are held stable until `out_ready`=1.
  - On `out_ready`, the result is consumed. The next state is CALC if a new operand set is accepted in the same cycle, otherwise IDLE.
- `in_ready` = IDLE || (DONE && `out_ready`). This is a combinational path from `out_ready` to `in_ready`, and it is intentional.
- In CALC, `in_valid` is ignored and the operand registers are not disturbed.
- Inputs `a` and `b` need not stay stable after accept.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `prod`=0, acc=0, `cnt`=0.
- Latency: accept at edge k gives `out_valid`=1 after edge k+ND. That is 12 cycles at the defaults.
- Throughput: one result every ND+1 cycles in back-to-back operation (accept in the DONE cycle with `out_ready`=1).
- `busy`=1 exactly for the ND cycles following an accept.
- Reset asserted mid-CALC or mid-DONE: all state returns to reset values immediately (asynchronous). The in-flight result is discarded and never presented.
- An X on `b` while `sq_mode`=1 must not propagate into `prod`.

## Structure
- Shared package `ecdh_pkg` holds:
  - BW_GF default.
  - BW_DIGIT default.
  - ND function.
  - state enum {IDLE, CALC, DONE}.
- One natural sub-module, `mult_digit_pe`:
  - combinational A_r × digit + acc_hi.
  - kept separate so it can be retimed or pipelined later.
- Control FSM, counter, acc and output register stay in `mult_digit_serial`.

## Test plan
- a=1, b=1, `out_ready`=1 → `out_valid` after exactly 12 cycles with `prod`=1. `busy` is high for 12 cycles.
- a=b=2^192−1 → `prod`=2^384−2^193+1.
- `sq_mode`=1, a=0x3, b=all-X → `prod`=0x9.
- `out_ready` held low 5 cycles in DONE → `prod` and `out_valid` stable, `in_ready`=0, and an `in_valid` pulse meanwhile is not accepted.
- Back-to-back issue:
  - setup: `out_ready`=1 and `in_valid`=1 in the DONE cycle, with a=2, b=3 as the second operand set.
  - first result is consumed.
  - second result 0x6 appears 12 cycles later.
  - no IDLE cycle occurs between the two operations.
- `rst` pulsed at CALC cycle 5:
  - all outputs return to reset values at once.
  - the next accept (a=5, b=7) yields 0x23 at standard latency.
- Additional run: repeat the first two scenarios at BW_DIGIT=32 (ND=6) with 6-cycle latency.
